// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI-lite widths, response codes, one-hot master states and read byte-mask helper
package axi_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    WR_AW_W = 5'b00010,
    WR_RESP = 5'b00100,
    RD_AR   = 5'b01000,
    RD_DATA = 5'b10000
  } state_t;
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < STRB_W; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction
endpackage

// File: rtl/axi_wdog_cnt.sv
// axi_wdog_cnt: handshake wait counter (clk, rst_n async low, clear in) raising expired when it reaches TIMEOUT-1
module axi_wdog_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : cnt + W'(1);
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/axi_master_fsm.sv
// axi_master_fsm: single-beat AXI-lite master; user cmd (i_*) in, status (o_*) out, AW/W/B/AR/R channels, registered outputs, handshake watchdog abort
module axi_master_fsm
  import axi_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              M_ACLK,
  input  logic              M_ARRESET_N,
  input  logic              i_wr_req,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [STRB_W-1:0] i_rmask,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_resp,
  output logic              o_timeout,
  output logic              M_AWVALID,
  output logic [ADDR_W-1:0] M_AWADDR,
  input  logic              S_AWREADY,
  output logic              M_WVALID,
  output logic [DATA_W-1:0] M_WDATA,
  output logic [STRB_W-1:0] M_WSTRB,
  input  logic              S_WREADY,
  input  logic              S_BVALID,
  input  logic [1:0]        S_BRESP,
  output logic              M_BREADY,
  output logic              M_ARVALID,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic [STRB_W-1:0] M_BLEN,
  input  logic              S_ARREADY,
  input  logic              S_RVALID,
  input  logic [DATA_W-1:0] S_RDATA,
  output logic              M_RREADY
);
  state_t state, state_n;
  logic awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, done_n, timeout_n;
  logic [ADDR_W-1:0] awaddr_n, araddr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic [STRB_W-1:0] wstrb_n, blen_n;
  logic [1:0] resp_n;
  logic hs, expired;
  assign hs = (M_AWVALID & S_AWREADY) | (M_WVALID & S_WREADY) | (M_BREADY & S_BVALID)
            | (M_ARVALID & S_ARREADY) | (M_RREADY & S_RVALID);
  axi_wdog_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(M_ACLK),
    .rst_n(M_ARRESET_N),
    .clear(hs || state_n != state || state == IDLE),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    awvalid_n = M_AWVALID;
    awaddr_n = M_AWADDR;
    wvalid_n = M_WVALID;
    wdata_n = M_WDATA;
    wstrb_n = M_WSTRB;
    bready_n = M_BREADY;
    arvalid_n = M_ARVALID;
    araddr_n = M_ARADDR;
    blen_n = M_BLEN;
    rready_n = M_RREADY;
    rdata_n = o_rdata;
    resp_n = o_resp;
    done_n = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      IDLE:
        if (i_wr_req) begin
          awaddr_n = i_addr;
          wdata_n = i_wdata;
          wstrb_n = i_wstrb;
          awvalid_n = 1'b1;
          wvalid_n = 1'b1;
          state_n = WR_AW_W;
        end else if (i_rd_req) begin
          araddr_n = i_addr;
          blen_n = i_rmask;
          arvalid_n = 1'b1;
          state_n = RD_AR;
        end
      WR_AW_W: begin
        awvalid_n = M_AWVALID & ~S_AWREADY;
        wvalid_n = M_WVALID & ~S_WREADY;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n = WR_RESP;
        end
      end
      WR_RESP:
        if (S_BVALID) begin
          resp_n = S_BRESP;
          done_n = 1'b1;
          bready_n = 1'b0;
          state_n = IDLE;
        end
      RD_AR:
        if (S_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n = 1'b1;
          state_n = RD_DATA;
        end
      RD_DATA:
        if (S_RVALID) begin
          rdata_n = mask_bytes(S_RDATA, M_BLEN);
          resp_n = RESP_OKAY;
          done_n = 1'b1;
          rready_n = 1'b0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    if (expired && state != IDLE) begin
      awvalid_n = 1'b0;
      wvalid_n = 1'b0;
      bready_n = 1'b0;
      arvalid_n = 1'b0;
      rready_n = 1'b0;
      resp_n = RESP_SLVERR;
      done_n = 1'b1;
      timeout_n = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge M_ACLK or negedge M_ARRESET_N)
    if (!M_ARRESET_N) begin
      state <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_timeout <= 1'b0;
      o_resp <= RESP_OKAY;
      o_rdata <= '0;
      M_AWVALID <= 1'b0;
      M_AWADDR <= '0;
      M_WVALID <= 1'b0;
      M_WDATA <= '0;
      M_WSTRB <= '0;
      M_BREADY <= 1'b0;
      M_ARVALID <= 1'b0;
      M_ARADDR <= '0;
      M_BLEN <= '0;
      M_RREADY <= 1'b0;
    end else begin
      state <= state_n;
      o_busy <= state_n != IDLE;
      o_done <= done_n;
      o_timeout <= timeout_n;
      o_resp <= resp_n;
      o_rdata <= rdata_n;
      M_AWVALID <= awvalid_n;
      M_AWADDR <= awaddr_n;
      M_WVALID <= wvalid_n;
      M_WDATA <= wdata_n;
      M_WSTRB <= wstrb_n;
      M_BREADY <= bready_n;
      M_ARVALID <= arvalid_n;
      M_ARADDR <= araddr_n;
      M_BLEN <= blen_n;
      M_RREADY <= rready_n;
    end
endmodule

// File: tb/tb_axi_master_fsm.sv
// tb_axi_master_fsm: scoreboard bench with delay-configurable slave model for axi_master_fsm
module tb_axi_master_fsm;
  logic M_ACLK = 1'b0, M_ARRESET_N = 1'b0;
  logic i_wr_req = 1'b0, i_rd_req = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [3:0] i_wstrb = '0, i_rmask = '0;
  logic o_busy, o_done, o_timeout;
  logic [31:0] o_rdata;
  logic [1:0] o_resp;
  logic M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
  logic [3:0] M_WSTRB, M_BLEN;
  logic S_AWREADY = 1'b0, S_WREADY = 1'b0, S_BVALID = 1'b0, S_ARREADY = 1'b0, S_RVALID = 1'b0;
  logic [1:0] S_BRESP = 2'b00;
  logic [31:0] S_RDATA = '0;
  typedef struct {logic [31:0] rdata; logic [1:0] resp; logic tmo;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0, done_cnt = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  logic r_ovr = 1'b0, ar_seen = 1'b0;
  logic [31:0] r_val = '0, exp_rd = '0, s_aw = '0, s_wd = '0, s_ar = '0;
  logic [3:0] s_ws = '0;
  logic [1:0] b_resp = 2'b00;
  logic [31:0] mem [logic [31:0]];
  axi_master_fsm #(.TIMEOUT(16)) dut (
    .M_ACLK(M_ACLK), .M_ARRESET_N(M_ARRESET_N),
    .i_wr_req(i_wr_req), .i_rd_req(i_rd_req), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_rmask(i_rmask),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_resp(o_resp), .o_timeout(o_timeout),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_BLEN(M_BLEN), .S_ARREADY(S_ARREADY),
    .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .M_RREADY(M_RREADY)
  );
  always #5 M_ACLK = ~M_ACLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic expect_done(input logic [31:0] rd, input logic [1:0] rs, input logic t);
    exp_t e;
    e.rdata = rd;
    e.resp = rs;
    e.tmo = t;
    sb.push_back(e);
  endtask
  task automatic issue(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    i_wr_req = wr;
    i_rd_req = rd;
    i_addr = a;
    i_wdata = d;
    i_wstrb = m;
    i_rmask = m;
    @(negedge M_ACLK);
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!o_done && k < 60) begin
      @(negedge M_ACLK);
      ar_seen |= M_ARVALID;
      k++;
    end
    if (!o_done) chk("done_wait", 0, 1);
  endtask
  initial forever begin
    @(negedge M_ACLK);
    S_AWREADY = M_AWVALID && aw_dly >= 0 && aw_n >= aw_dly;
    S_WREADY = M_WVALID && w_dly >= 0 && w_n >= w_dly;
    S_ARREADY = M_ARVALID && ar_dly >= 0 && ar_n >= ar_dly;
    aw_n = M_AWVALID ? aw_n + 1 : 0;
    w_n = M_WVALID ? w_n + 1 : 0;
    ar_n = M_ARVALID ? ar_n + 1 : 0;
    if (S_AWREADY) s_aw = M_AWADDR;
    if (S_WREADY) begin
      s_wd = M_WDATA;
      s_ws = M_WSTRB;
    end
    if (S_ARREADY) s_ar = M_ARADDR;
    S_BVALID = M_BREADY && b_dly >= 0 && b_n == b_dly;
    S_RVALID = M_RREADY && r_dly >= 0 && r_n == r_dly;
    b_n = M_BREADY ? b_n + 1 : 0;
    r_n = M_RREADY ? r_n + 1 : 0;
    S_BRESP = b_resp;
    if (S_BVALID) begin
      logic [31:0] old;
      old = mem.exists(s_aw) ? mem[s_aw] : 32'h0;
      for (int i = 0; i < 4; i++) if (s_ws[i]) old[8*i +: 8] = s_wd[8*i +: 8];
      mem[s_aw] = old;
    end
    if (S_RVALID) S_RDATA = r_ovr ? r_val : (mem.exists(s_ar) ? mem[s_ar] : 32'h0);
  end
  initial forever begin
    @(negedge M_ACLK);
    if (M_ARRESET_N && o_done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", o_rdata, e.rdata);
        chk("sb_resp", {30'd0, o_resp}, {30'd0, e.resp});
        chk("sb_timeout", {31'd0, o_timeout}, {31'd0, e.tmo});
      end
    end
  end
  initial begin
    int d0, k;
    repeat (3) @(negedge M_ACLK);
    chk("rst_ctrl", {o_busy, o_done, o_timeout, o_resp, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
    chk("rst_data", o_rdata | M_AWADDR | M_WDATA | M_ARADDR | {M_WSTRB, M_BLEN}, 0);
    M_ARRESET_N = 1'b1;
    @(negedge M_ACLK);
    chk("idle_busy", {31'd0, o_busy}, 0);
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(1, 0, 32'h04, 32'hA1B2C3D4, 4'hF);
    chk("wr_valid_lat1", {M_AWVALID, M_WVALID, o_busy}, 3'b111);
    chk("wr_awaddr", M_AWADDR, 32'h04);
    chk("wr_wdata", M_WDATA, 32'hA1B2C3D4);
    wait_done();
    @(negedge M_ACLK);
    exp_rd = 32'hA1B2C3D4;
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(0, 1, 32'h04, 32'h0, 4'hF);
    chk("rd_arvalid", {M_ARVALID, M_ARADDR[7:0]}, {1'b1, 8'h04});
    wait_done();
    @(negedge M_ACLK);
    aw_dly = 3;
    d0 = done_cnt;
    ar_seen = 1'b0;
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(1, 0, 32'h10, 32'h55667788, 4'hF);
    i_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge M_ACLK);
      ar_seen |= M_ARVALID;
      chk("wfirst_wvalid", {31'd0, M_WVALID}, 0);
      chk("wfirst_aw_hold", {M_AWVALID, M_AWADDR[30:0]}, {1'b1, 31'h10});
    end
    i_rd_req = 1'b0;
    wait_done();
    repeat (2) @(negedge M_ACLK);
    chk("wfirst_one_done", done_cnt - d0, 1);
    chk("busy_rd_ignored", {31'd0, ar_seen}, 0);
    aw_dly = 0;
    ar_dly = 0;
    r_dly = 1;
    r_ovr = 1'b1;
    r_val = 32'h11223344;
    exp_rd = 32'h00220044;
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(0, 1, 32'h08, 32'h0, 4'b0101);
    chk("rd_blen", {28'd0, M_BLEN}, 4'b0101);
    chk("rd_araddr", M_ARADDR, 32'h08);
    wait_done();
    @(negedge M_ACLK);
    r_ovr = 1'b0;
    ar_dly = -1;
    expect_done(exp_rd, 2'b10, 1'b1);
    issue(0, 1, 32'h0C, 32'h0, 4'hF);
    k = 0;
    while (!o_done && k < 40) begin
      @(negedge M_ACLK);
      k++;
    end
    chk("tmo_cycle", k, 16);
    chk("tmo_flags", {o_done, o_timeout, M_ARVALID, o_busy}, 4'b1100);
    @(negedge M_ACLK);
    chk("tmo_after", {M_ARVALID, o_done, o_timeout}, 0);
    ar_dly = 0;
    ar_seen = 1'b0;
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(1, 1, 32'h14, 32'h0BADBEEF, 4'h3);
    chk("prio_valids", {M_AWVALID, M_WVALID, M_ARVALID}, 3'b110);
    ar_seen |= M_ARVALID;
    wait_done();
    chk("prio_no_ar", {31'd0, ar_seen}, 0);
    @(negedge M_ACLK);
    b_dly = -1;
    issue(1, 0, 32'h18, 32'h12345678, 4'hF);
    k = 0;
    while (!M_BREADY && k < 10) begin
      @(negedge M_ACLK);
      k++;
    end
    chk("pre_rst_bready", {31'd0, M_BREADY}, 1);
    #2 M_ARRESET_N = 1'b0;
    #1;
    chk("async_rst_ctrl", {o_busy, o_done, o_timeout, o_resp, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
    chk("async_rst_rdata", o_rdata, 0);
    chk("async_rst_addr", M_AWADDR | M_ARADDR, 0);
    chk("async_rst_wd", M_WDATA | {24'd0, M_WSTRB, M_BLEN}, 0);
    @(negedge M_ACLK);
    b_dly = 0;
    b_resp = 2'b10;
    exp_rd = 32'h0;
    M_ARRESET_N = 1'b1;
    expect_done(exp_rd, 2'b10, 1'b0);
    issue(1, 0, 32'h20, 32'hCAFEF00D, 4'hF);
    chk("resume_aw", {31'd0, M_AWVALID}, 1);
    wait_done();
    b_resp = 2'b00;
    exp_rd = 32'hCAFE0000;
    expect_done(exp_rd, 2'b00, 1'b0);
    issue(0, 1, 32'h20, 32'h0, 4'b1100);
    chk("b2b_accept", {31'd0, M_ARVALID}, 1);
    wait_done();
    repeat (2) @(negedge M_ACLK);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi_master_fsm.md
AXI_MASTER_FSM -- requirements
Module: axi_master_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the max cycles waited for any single handshake before abort.
REQ-002 SHALL have port M_ACLK  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port M_ARRESET_N  in  1  the reset, asynchronous and active-low.
REQ-004 SHALL have user ports i_wr_req in 1, i_rd_req in 1, i_addr in 32, i_wdata in 32, i_wstrb in 4, i_rmask in 4; these are command inputs, sampled only in IDLE.
REQ-005 SHALL have user ports o_busy out 1, o_done out 1 (one-cycle pulse), o_rdata out 32, o_resp out 2, o_timeout out 1 (pulse).
REQ-006 SHALL have AW channel ports M_AWVALID out 1, M_AWADDR out 32, S_AWREADY in 1.
REQ-007 SHALL have W channel ports M_WVALID out 1, M_WDATA out 32, M_WSTRB out 4, S_WREADY in 1.
REQ-008 SHALL have B channel ports S_BVALID in 1, S_BRESP in 2, M_BREADY out 1.
REQ-009 SHALL have AR/R channel ports M_ARVALID out 1, M_ARADDR out 32, M_BLEN out 4 (read byte mask), S_ARREADY in 1, S_RVALID in 1, S_RDATA in 32, M_RREADY out 1.

Function
REQ-010 SHALL implement states IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA; all outputs SHALL be registered.
REQ-011 SHALL, in IDLE on an edge with i_wr_req=1, latch i_addr, i_wdata and i_wstrb, and assert M_AWVALID and M_WVALID from the next cycle (latency 1), entering WR_AW_W.
REQ-012 SHALL, in IDLE on an edge with i_rd_req=1 and i_wr_req=0, latch i_addr and i_rmask, and assert M_ARVALID from the next cycle, entering RD_AR.
REQ-013 SHALL give write priority when i_wr_req and i_rd_req are high in the same edge; the read is dropped, not queued, and the requester reissues it.
REQ-014 SHALL hold each VALID high, with address, data and strobe stable, until its READY is sampled high; a transfer occurs on any edge with VALID&READY=1.
REQ-015 SHALL complete the AW and W handshakes independently in WR_AW_W, in either order or the same edge; each VALID drops after its own handshake; the FSM enters WR_RESP once both are done.
REQ-016 SHALL, in WR_RESP, hold M_BREADY=1; on S_BVALID=1 it captures S_BRESP into o_resp, pulses o_done, drops M_BREADY and returns to IDLE.
REQ-017 SHALL drive M_BLEN with the latched i_rmask while M_ARVALID=1; after the AR handshake it enters RD_DATA with M_RREADY=1.
REQ-018 SHALL, in RD_DATA on S_RVALID=1, load o_rdata with S_RDATA for bytes whose mask bit is set and zero for other bytes, set o_resp=2'b00, pulse o_done and return to IDLE.
REQ-019 SHALL keep o_rdata stable outside a read completion; a write SHALL NOT alter o_rdata.
REQ-020 SHALL keep a wait counter cleared on every state entry and every handshake, incremented each cycle otherwise.
REQ-021 SHALL abort when the wait counter reaches TIMEOUT-1 in a non-IDLE state: drop all VALID/READY outputs, set o_resp=2'b10, pulse o_done and o_timeout together, and return to IDLE. This VALID withdrawal is an accepted error-recovery exception.
REQ-022 SHALL assert o_busy=1 in every non-IDLE state and drive o_busy=0 in IDLE; requests while busy SHALL be ignored.
REQ-023 SHALL allow back-to-back commands: a request sampled in IDLE on the edge after o_done is accepted.

Reset
REQ-024 SHALL, on M_ARRESET_N=0 at any time including mid-transfer, immediately force state=IDLE, all VALID/READY outputs=0, o_done=0, o_timeout=0, o_busy=0, o_resp=2'b00, o_rdata=0, M_AWADDR/M_WDATA/M_ARADDR=0, M_WSTRB/M_BLEN=0, and wait counter=0.
REQ-025 SHALL resume accepting requests on the first rising edge after M_ARRESET_N returns high.

Structure
REQ-026 SHALL take state encoding (one-hot, 5 bits), response codes OKAY=2'b00 and SLVERR=2'b10, and address/data widths from shared package axi_pkg, also used by the slave.
REQ-027 SHALL place the wait counter and timeout compare in the single sub-module axi_wdog_cnt (ports: clk, rst_n, clear, expired).

Verification
REQ-028 SHALL test: write addr=0x04, data=0xA1B2C3D4, strb=4'hF with slave AWREADY/WREADY same cycle -> BVALID with resp 00 gives o_done=1, o_resp=00; then read addr=0x04, mask=4'hF -> o_rdata=0xA1B2C3D4.
REQ-029 SHALL test: WREADY 3 cycles before AWREADY -> M_WVALID drops after W handshake, M_AWVALID held with addr stable; exactly one o_done.
REQ-030 SHALL test: read addr=0x08, mask=4'b0101, S_RDATA=0x11223344 -> o_rdata=0x00220044.
REQ-031 SHALL test: slave never asserts ARREADY with TIMEOUT=16 -> o_done=o_timeout=1 and o_resp=10 on cycle 16 after M_ARVALID rise; M_ARVALID=0 after.
REQ-032 SHALL test: i_wr_req and i_rd_req in the same cycle -> only AW/W issued, no M_ARVALID; also assert reset mid WR_RESP -> all outputs 0 without waiting for a clock edge.
